// File: rtl/clint_ctrl.sv
// clint_ctrl -- core-local interrupt/trap sequencer.
//
// Purpose:
//   Detects ECALL/EBREAK, enabled external interrupts and MRET in the execute
//   stage. It stalls the pipeline, writes the trap CSRs (mepc, mcause, mstatus)
//   or the MRET mstatus update one per cycle, and then pulses a PC redirect.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   inst_i, inst_addr_i   execute-stage instruction and its PC
//   jump_flag_i/addr_i    execute-stage jump in flight (async mepc source)
//   int_flag_i            external interrupt lines (any bit = request)
//   csr_mtvec_i/mepc_i/mstatus_i  live CSR values
//   clint_wen_o/waddr_o/wdata_o   CSR write port into the register file
//   hold_flag_o           pipeline stall request
//   int_assert_o/addr_o   one-cycle redirect pulse and its target
module clint_ctrl #(
  parameter logic [31:0] MCAUSE_EXT = 32'h8000_000B,
  parameter int unsigned MIE_BIT    = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_addr_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic [7:0]  int_flag_i,
  input  logic [31:0] csr_mtvec_i,
  input  logic [31:0] csr_mepc_i,
  input  logic [31:0] csr_mstatus_i,
  output logic        clint_wen_o,
  output logic [31:0] clint_waddr_o,
  output logic [31:0] clint_wdata_o,
  output logic        hold_flag_o,
  output logic        int_assert_o,
  output logic [31:0] int_addr_o
);

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  localparam logic [31:0] CSR_MSTATUS = 32'h0000_0300;
  localparam logic [31:0] CSR_MEPC    = 32'h0000_0341;
  localparam logic [31:0] CSR_MCAUSE  = 32'h0000_0342;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_W_MEPC    = 3'd1,
    S_W_MCAUSE  = 3'd2,
    S_W_MSTATUS = 3'd3,
    S_W_MRET    = 3'd4,
    S_ASSERT    = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic        r_is_mret;

  logic        w_is_ecall;
  logic        w_is_ebreak;
  logic        w_is_mret;
  logic        w_sync;
  logic        w_async;
  logic        w_idle;
  logic        w_trap_evt;
  logic        w_mret_evt;
  logic [31:0] w_cap_mepc;
  logic [31:0] w_cap_mcause;
  logic [31:0] w_mst_trap;
  logic [31:0] w_mst_mret;

  assign w_is_ecall  = (inst_i == INST_ECALL);
  assign w_is_ebreak = (inst_i == INST_EBREAK);
  assign w_is_mret   = (inst_i == INST_MRET);
  assign w_sync      = w_is_ecall || w_is_ebreak;
  assign w_async     = (int_flag_i != 8'h00) && csr_mstatus_i[MIE_BIT];
  assign w_idle      = (r_state == S_IDLE) && !rst_i;
  // Priority: synchronous trap, then interrupt, then MRET.
  assign w_trap_evt  = w_idle && (w_sync || w_async);
  assign w_mret_evt  = w_idle && !w_sync && !w_async && w_is_mret;

  // An interrupt taken while a jump is resolving must resume at the jump target.
  assign w_cap_mepc   = w_sync ? inst_addr_i : (jump_flag_i ? jump_addr_i : inst_addr_i);
  assign w_cap_mcause = w_is_ecall  ? 32'd11 :
                        w_is_ebreak ? 32'd3  : MCAUSE_EXT;

  // mstatus images for trap entry (MPIE<=MIE, MIE<=0) and MRET (MIE<=MPIE, MPIE<=1).
  always_comb begin
    w_mst_trap          = csr_mstatus_i;
    w_mst_trap[7]       = csr_mstatus_i[MIE_BIT];
    w_mst_trap[MIE_BIT] = 1'b0;
    w_mst_mret          = csr_mstatus_i;
    w_mst_mret[MIE_BIT] = csr_mstatus_i[7];
    w_mst_mret[7]       = 1'b1;
  end

  // State register and capture of the trap context at the event cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_mepc    <= 32'h0000_0000;
      r_mcause  <= 32'h0000_0000;
      r_is_mret <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_trap_evt) begin
        r_mepc    <= w_cap_mepc;
        r_mcause  <= w_cap_mcause;
        r_is_mret <= 1'b0;
      end else if (w_mret_evt) begin
        r_is_mret <= 1'b1;
      end
    end
  end

  // Next-state and output decode.
  always_comb begin
    w_next        = r_state;
    clint_wen_o   = 1'b0;
    clint_waddr_o = 32'h0000_0000;
    clint_wdata_o = 32'h0000_0000;
    hold_flag_o   = 1'b0;
    int_assert_o  = 1'b0;
    int_addr_o    = 32'h0000_0000;
    case (r_state)
      S_IDLE: begin
        if (w_trap_evt) begin
          w_next      = S_W_MEPC;
          hold_flag_o = 1'b1;
        end else if (w_mret_evt) begin
          w_next      = S_W_MRET;
          hold_flag_o = 1'b1;
        end else begin
          w_next      = S_IDLE;
        end
      end
      S_W_MEPC: begin
        w_next        = S_W_MCAUSE;
        hold_flag_o   = 1'b1;
        clint_wen_o   = 1'b1;
        clint_waddr_o = CSR_MEPC;
        clint_wdata_o = r_mepc;
      end
      S_W_MCAUSE: begin
        w_next        = S_W_MSTATUS;
        hold_flag_o   = 1'b1;
        clint_wen_o   = 1'b1;
        clint_waddr_o = CSR_MCAUSE;
        clint_wdata_o = r_mcause;
      end
      S_W_MSTATUS: begin
        w_next        = S_ASSERT;
        hold_flag_o   = 1'b1;
        clint_wen_o   = 1'b1;
        clint_waddr_o = CSR_MSTATUS;
        clint_wdata_o = w_mst_trap;
      end
      S_W_MRET: begin
        w_next        = S_ASSERT;
        hold_flag_o   = 1'b1;
        clint_wen_o   = 1'b1;
        clint_waddr_o = CSR_MSTATUS;
        clint_wdata_o = w_mst_mret;
      end
      S_ASSERT: begin
        w_next       = S_IDLE;
        hold_flag_o  = 1'b1;
        int_assert_o = 1'b1;
        int_addr_o   = r_is_mret ? csr_mepc_i : csr_mtvec_i;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_clint_ctrl.sv
// tb_clint_ctrl -- directed self-checking bench for clint_ctrl.
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit later.
module tb_clint_ctrl;

  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] MRET   = 32'h3020_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] inst_i, inst_addr_i, jump_addr_i;
  logic        jump_flag_i;
  logic [7:0]  int_flag_i;
  logic [31:0] csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
  logic        clint_wen_o, hold_flag_o, int_assert_o;
  logic [31:0] clint_waddr_o, clint_wdata_o, int_addr_o;

  int checks_r   = 0;
  int failures_r = 0;

  clint_ctrl dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .inst_i        (inst_i),
    .inst_addr_i   (inst_addr_i),
    .jump_flag_i   (jump_flag_i),
    .jump_addr_i   (jump_addr_i),
    .int_flag_i    (int_flag_i),
    .csr_mtvec_i   (csr_mtvec_i),
    .csr_mepc_i    (csr_mepc_i),
    .csr_mstatus_i (csr_mstatus_i),
    .clint_wen_o   (clint_wen_o),
    .clint_waddr_o (clint_waddr_o),
    .clint_wdata_o (clint_wdata_o),
    .hold_flag_o   (hold_flag_o),
    .int_assert_o  (int_assert_o),
    .int_addr_o    (int_addr_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_r++;
    if (got !== exp) begin
      failures_r++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Sample all outputs against one expected vector.
  task automatic expect_out(input string tag, input logic wen, input logic [31:0] waddr,
                            input logic [31:0] wdata, input logic hold,
                            input logic ast, input logic [31:0] addr);
    #1;
    check_val({tag, ".wen"},   {31'd0, clint_wen_o},  {31'd0, wen});
    check_val({tag, ".waddr"}, clint_waddr_o,         waddr);
    check_val({tag, ".wdata"}, clint_wdata_o,         wdata);
    check_val({tag, ".hold"},  {31'd0, hold_flag_o},  {31'd0, hold});
    check_val({tag, ".ast"},   {31'd0, int_assert_o}, {31'd0, ast});
    check_val({tag, ".addr"},  int_addr_o,            addr);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1; inst_i = NOP; inst_addr_i = 32'h0; jump_flag_i = 1'b0;
    jump_addr_i = 32'h0; int_flag_i = 8'h00; csr_mtvec_i = 32'h80;
    csr_mepc_i = 32'h104; csr_mstatus_i = 32'h8;
    tick(); tick();
    expect_out("rst", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    rst_i = 1'b0;
    tick();
    expect_out("idle", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);

    // ECALL at 0x100
    tick();
    inst_i = ECALL; inst_addr_i = 32'h100;
    expect_out("ecall.T", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    tick(); inst_i = NOP; inst_addr_i = 32'h104;
    expect_out("ecall.T1", 1'b1, 32'h341, 32'h100, 1'b1, 1'b0, 32'h0);
    tick();
    expect_out("ecall.T2", 1'b1, 32'h342, 32'd11, 1'b1, 1'b0, 32'h0);
    tick();
    expect_out("ecall.T3", 1'b1, 32'h300, 32'h80, 1'b1, 1'b0, 32'h0);
    tick();
    expect_out("ecall.T4", 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h80);
    tick();
    expect_out("ecall.T5", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);

    // EBREAK at 0x40
    tick();
    inst_i = EBREAK; inst_addr_i = 32'h40;
    expect_out("ebrk.T", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    tick(); inst_i = NOP;
    expect_out("ebrk.T1", 1'b1, 32'h341, 32'h40, 1'b1, 1'b0, 32'h0);
    tick();
    expect_out("ebrk.T2", 1'b1, 32'h342, 32'd3, 1'b1, 1'b0, 32'h0);
    tick(); tick(); tick();

    // Interrupt during a jump: mepc takes the jump target
    int_flag_i = 8'h01; jump_flag_i = 1'b1; jump_addr_i = 32'h200; inst_addr_i = 32'h300;
    expect_out("irq.T", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    tick(); int_flag_i = 8'h00; jump_flag_i = 1'b0;
    expect_out("irq.T1", 1'b1, 32'h341, 32'h200, 1'b1, 1'b0, 32'h0);
    tick();
    expect_out("irq.T2", 1'b1, 32'h342, 32'h8000_000B, 1'b1, 1'b0, 32'h0);
    tick();
    expect_out("irq.T3", 1'b1, 32'h300, 32'h80, 1'b1, 1'b0, 32'h0);
    tick();
    expect_out("irq.T4", 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h80);
    tick();

    // Masked interrupt: nothing happens
    csr_mstatus_i = 32'h0; int_flag_i = 8'h01;
    expect_out("mask.T", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    expect_out("mask.T1", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    expect_out("mask.T2", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    int_flag_i = 8'h00;
    tick();

    // MRET: mstatus 0x80 -> 0x88, redirect to mepc
    csr_mstatus_i = 32'h80; inst_i = MRET;
    expect_out("mret.T", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    tick(); inst_i = NOP;
    expect_out("mret.T1", 1'b1, 32'h300, 32'h88, 1'b1, 1'b0, 32'h0);
    tick();
    expect_out("mret.T2", 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h104);
    tick();
    expect_out("mret.T3", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);

    // ECALL and interrupt together; the interrupt follows back-to-back
    csr_mstatus_i = 32'h8; inst_i = ECALL; inst_addr_i = 32'h500; int_flag_i = 8'hFF;
    tick(); inst_i = NOP; inst_addr_i = 32'h600;
    expect_out("both.T1", 1'b1, 32'h341, 32'h500, 1'b1, 1'b0, 32'h0);
    tick();
    expect_out("both.T2", 1'b1, 32'h342, 32'd11, 1'b1, 1'b0, 32'h0);
    tick();
    expect_out("both.T3", 1'b1, 32'h300, 32'h80, 1'b1, 1'b0, 32'h0);
    tick();
    expect_out("both.T4", 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h80);
    tick();
    expect_out("both.T5", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    tick(); int_flag_i = 8'h00;
    expect_out("both.T6", 1'b1, 32'h341, 32'h600, 1'b1, 1'b0, 32'h0);
    tick();
    expect_out("both.T7", 1'b1, 32'h342, 32'h8000_000B, 1'b1, 1'b0, 32'h0);
    tick(); tick(); tick();

    // Reset during W_MCAUSE aborts the sequence
    inst_i = ECALL; inst_addr_i = 32'h700;
    tick(); inst_i = NOP;
    tick();
    expect_out("abort.mcause", 1'b1, 32'h342, 32'd11, 1'b1, 1'b0, 32'h0);
    rst_i = 1'b1; inst_i = ECALL;
    tick();
    expect_out("abort.R1", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    expect_out("abort.R2", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    rst_i = 1'b0; inst_i = NOP;
    tick();
    expect_out("abort.P1", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    expect_out("abort.P2", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
    $finish;
  end

endmodule

// File: doc/clint_ctrl.md
CLINT_CTRL -- requirements
Module: clint_ctrl

Interface
REQ-001 SHALL have parameter MCAUSE_EXT, default 32'h8000_000B, mcause value written for an external interrupt.
REQ-002 SHALL have parameter MIE_BIT, default 3, mstatus bit index of MIE; MPIE is fixed at bit 7.
REQ-003 SHALL have port clk_i  in  1  sole clock, all state updates on its rising edge.
REQ-004 SHALL have port rst_i  in  1  synchronous active-high reset.
REQ-005 SHALL have port inst_i  in  32  instruction currently in the execute stage.
REQ-006 SHALL have port inst_addr_i  in  32  PC of inst_i.
REQ-007 SHALL have port jump_flag_i  in  1  execute stage is taking a jump this cycle.
REQ-008 SHALL have port jump_addr_i  in  32  target of that jump.
REQ-009 SHALL have port int_flag_i  in  8  external interrupt lines; any nonzero bit is a request.
REQ-010 SHALL have ports csr_mtvec_i, csr_mepc_i, csr_mstatus_i  in  32 each  live CSR values from the register file.
REQ-011 SHALL have port clint_wen_o  out  1  CSR write strobe into the register file clint port.
REQ-012 SHALL have port clint_waddr_o  out  32  CSR write address, zero-extended 12-bit.
REQ-013 SHALL have port clint_wdata_o  out  32  CSR write data.
REQ-014 SHALL have port hold_flag_o  out  1  pipeline stall request.
REQ-015 SHALL have port int_assert_o  out  1  one-cycle PC redirect pulse.
REQ-016 SHALL have port int_addr_o  out  32  redirect target, valid only while int_assert_o=1.

Function
REQ-017 SHALL decode ECALL=32'h0000_0073, EBREAK=32'h0010_0073, MRET=32'h3020_0073 as exact matches.
REQ-018 SHALL in IDLE sample events with priority: ECALL/EBREAK (sync) > external interrupt (int_flag_i!=0 and csr_mstatus_i[MIE_BIT]=1) > MRET.
REQ-019 SHALL implement states IDLE, W_MEPC, W_MCAUSE, W_MSTATUS, W_MRET, ASSERT; transitions: sync/async event IDLE->W_MEPC->W_MCAUSE->W_MSTATUS->ASSERT->IDLE; MRET IDLE->W_MRET->ASSERT->IDLE.
REQ-020 SHALL capture mepc value at event cycle: sync = inst_addr_i; async = jump_flag_i ? jump_addr_i : inst_addr_i.
REQ-021 SHALL capture mcause at event cycle: ECALL 32'd11, EBREAK 32'd3, interrupt MCAUSE_EXT.
REQ-022 SHALL in W_MEPC drive wen=1, waddr=32'h341, wdata=captured mepc.
REQ-023 SHALL in W_MCAUSE drive wen=1, waddr=32'h342, wdata=captured mcause.
REQ-024 SHALL in W_MSTATUS drive wen=1, waddr=32'h300, wdata=csr_mstatus_i with bit7<=old MIE bit, MIE bit<=0, other bits unchanged.
REQ-025 SHALL in W_MRET drive wen=1, waddr=32'h300, wdata=csr_mstatus_i with MIE bit<=old bit7, bit7<=1, other bits unchanged.
REQ-026 SHALL in ASSERT drive int_assert_o=1 for exactly one cycle, int_addr_o=csr_mtvec_i after trap, csr_mepc_i after MRET.
REQ-027 SHALL drive wen=0, waddr=0, wdata=0 in IDLE and ASSERT; int_addr_o=0 when int_assert_o=0.
REQ-028 SHALL assert hold_flag_o combinationally in the event-detect cycle and in every non-IDLE state, including ASSERT.
REQ-029 SHALL ignore all events while not in IDLE; requests still pending on return to IDLE are re-evaluated then.
REQ-030 SHALL latency: trap event at cycle T -> writes T+1..T+3, int_assert_o at T+4; MRET at T -> write T+1, int_assert_o at T+2.
REQ-031 SHALL allow back-to-back sequences: an event in the cycle after ASSERT starts a new sequence without a gap.

Reset
REQ-032 SHALL on rst_i=1 at a clock edge enter IDLE, clear captured mepc/mcause, and hold all outputs 0 from the next cycle.
REQ-033 SHALL when reset occurs mid-sequence abort it: no further CSR writes, no int_assert_o pulse.
REQ-034 SHALL while rst_i=1 ignore all event inputs.

Verification
REQ-035 ECALL at inst_addr_i=0x100, mtvec=0x80 -> writes 0x341<=0x100, 0x342<=11, 0x300 MIE cleared/MPIE set; T+4 int_assert_o=1, int_addr_o=0x80.
REQ-036 int_flag_i=0x01, mstatus=0x8, jump_flag_i=1, jump_addr_i=0x200 -> mepc<=0x200, mcause<=0x8000000B, mstatus<=0x80; redirect to mtvec.
REQ-037 int_flag_i=0x01 with mstatus=0x0 -> no write, hold_flag_o=0, no pulse.
REQ-038 MRET with mstatus=0x80, mepc=0x104 -> T+1 write 0x300<=0x88; T+2 int_assert_o=1, int_addr_o=0x104.
REQ-039 ECALL and int_flag_i=0xFF same cycle -> mcause<=11 only; interrupt ignored until IDLE.
REQ-040 rst_i=1 during W_MCAUSE -> no 0x300 write, no pulse, outputs 0 next cycle.
